// File: rtl/squash_io_adapter.sv
// Caravel-side adapter: gpio_ready-gated reset release FSM, Wishbone soft reset,
// OEB generation and button conditioning. Define BTN_DEBOUNCE_EN to add per-button debouncers.
module squash_io_adapter #(
   parameter int unsigned N_BTN           = 4,
   parameter int unsigned N_OUT           = 6,
   parameter int unsigned N_DBG           = 2,
   parameter int unsigned SETTLE_CYCLES   = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic             wb_clk_i,
   input  logic             ext_reset_n,
   input  logic             wb_rst_i,
   input  logic             gpio_ready,
   input  logic [N_BTN-1:0] btn_n_in,
   output logic [N_BTN-1:0] btn_n_out,
   output logic             design_reset,
   output logic [N_OUT-1:0] design_oeb,
   output logic [N_DBG-1:0] debug_oeb,
   output logic [1:0]       state_dbg
);

   localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RESET  = 2'd0,
      S_WAIT   = 2'd1,
      S_SETTLE = 2'd2,
      S_RUN    = 2'd3
   } state_t;

   state_t        state, state_next;
   logic          rdy_q, rdy_s, wb_rst_q;
   logic [SW-1:0] settle_cnt, settle_cnt_next;

   always_ff @(posedge wb_clk_i or negedge ext_reset_n) begin
      if (!ext_reset_n) begin
         rdy_q    <= 1'b0;
         rdy_s    <= 1'b0;
         wb_rst_q <= 1'b0;
      end else begin
         rdy_q    <= gpio_ready;
         rdy_s    <= rdy_q;
         wb_rst_q <= wb_rst_i;
      end
   end

   always_comb begin
      state_next      = state;
      settle_cnt_next = '0;
      if (wb_rst_q) begin
         state_next = S_RESET;
      end else begin
         case (state)
            S_RESET:  state_next = S_WAIT;
            S_WAIT:   if (rdy_s) state_next = S_SETTLE;
            S_SETTLE: begin
               if (!rdy_s)
                  state_next = S_WAIT;
               else if (settle_cnt == SETTLE_LAST)
                  state_next = S_RUN;
               else
                  settle_cnt_next = settle_cnt + 1'b1;
            end
            S_RUN:    state_next = S_RUN;
            default:  state_next = S_RESET;
         endcase
      end
   end

   // Outputs are registered from state_next so they switch on the same edge as the FSM.
   always_ff @(posedge wb_clk_i or negedge ext_reset_n) begin
      if (!ext_reset_n) begin
         state        <= S_RESET;
         settle_cnt   <= '0;
         design_reset <= 1'b1;
         design_oeb   <= '1;
      end else begin
         state        <= state_next;
         settle_cnt   <= settle_cnt_next;
         design_reset <= (state_next != S_RUN);
         design_oeb   <= {N_OUT{state_next != S_RUN}};
      end
   end

   assign state_dbg = state;
   assign debug_oeb = '0;

   logic [N_BTN-1:0] btn_q, btn_s;

   always_ff @(posedge wb_clk_i or negedge ext_reset_n) begin
      if (!ext_reset_n) begin
         btn_q <= '1;
         btn_s <= '1;
      end else begin
         btn_q <= btn_n_in;
         btn_s <= btn_q;
      end
   end

`ifdef BTN_DEBOUNCE_EN
   localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [DW-1:0]    db_cnt [N_BTN];
   logic [N_BTN-1:0] btn_out;

   // Any agreeing sample clears the run, so only an unbroken disagreement flips the output.
   always_ff @(posedge wb_clk_i or negedge ext_reset_n) begin
      if (!ext_reset_n) begin
         btn_out <= '1;
         for (int unsigned i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N_BTN; i++) begin
            if (btn_s[i] == btn_out[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               btn_out[i] <= btn_s[i];
               db_cnt[i]  <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign btn_n_out = btn_out;
`else
   assign btn_n_out = btn_s;
`endif

endmodule
